// File: rtl/dec_ram_pingpong_ctrl_if.sv
// Bus bundle between the ping-pong controller, the frame loader, the
// decoder read port and the DEC_RAM macro. The controller takes the slave
// modport and the surrounding environment takes the master modport.
interface dec_ram_pingpong_ctrl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_frame_avail;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_grant;
    logic                  rd_data_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_bank_done;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  ram_we;
    logic                  ram_cs;
    logic                  ram_rs;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic [3:0]            bank_state;

    modport slave (
        input  wr_valid, wr_data, rd_req, rd_addr, rd_bank_done, ram_data_out,
        output wr_ready, rd_frame_avail, rd_grant, rd_data_valid, rd_data,
               ram_address, ram_data_in, ram_we, ram_cs, ram_rs, bank_state
    );

    modport master (
        output wr_valid, wr_data, rd_req, rd_addr, rd_bank_done, ram_data_out,
        input  wr_ready, rd_frame_avail, rd_grant, rd_data_valid, rd_data,
               ram_address, ram_data_in, ram_we, ram_cs, ram_rs, bank_state
    );
endinterface

// File: rtl/dec_ram_pingpong_ctrl.sv
// Ping-pong controller for the two-bank DEC_RAM. A loader fills one bank
// while the decoder reads the other; one RAM access is issued per cycle,
// with a fair alternation between writer and reader when both want it.
module dec_ram_pingpong_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    dec_ram_pingpong_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        READ  = 2'd3
    } bank_state_t;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    bank_state_t           bank_q [2];
    bank_state_t           bank_d [2];
    logic                  wr_bank_q;
    logic                  wr_bank_d;
    logic                  rd_bank_q;
    logic                  rd_bank_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q;
    logic [ADDR_WIDTH-1:0] wr_cnt_d;
    grant_t                last_grant_q;
    grant_t                last_grant_d;
    logic                  rd_valid_q;

    bank_state_t           wr_bank_state;
    bank_state_t           rd_bank_state;
    logic                  frame_avail;
    logic                  wr_eligible;
    logic                  rd_eligible;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  release_bank;

    // Eligibility and arbitration; rst gates requests so outputs stay low while reset is held.
    always_comb begin
        wr_bank_state = bank_q[wr_bank_q];
        rd_bank_state = bank_q[rd_bank_q];
        frame_avail   = (rd_bank_state == FULL) || (rd_bank_state == READ);
        wr_eligible   = !rst && bus.wr_valid &&
                        ((wr_bank_state == EMPTY) || (wr_bank_state == FILL));
        rd_eligible   = !rst && bus.rd_req && frame_avail;
        grant_rd      = rd_eligible && (!wr_eligible || (last_grant_q == GRANT_WRITE));
        grant_wr      = wr_eligible && !grant_rd;
        release_bank  = !rst && bus.rd_bank_done && frame_avail;
    end

    // Next-state: write progress, first-read marking, then bank release (release wins).
    always_comb begin
        bank_d[0]    = bank_q[0];
        bank_d[1]    = bank_q[1];
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_cnt_d     = wr_cnt_q;
        last_grant_d = last_grant_q;

        if (wr_eligible && rd_eligible) begin
            last_grant_d = grant_rd ? GRANT_READ : GRANT_WRITE;
        end

        if (grant_wr) begin
            if (wr_cnt_q == LAST_ADDR) begin
                bank_d[wr_bank_q] = FULL;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_bank_state == EMPTY) begin
                    bank_d[wr_bank_q] = FILL;
                end
            end
        end

        if (grant_rd && (rd_bank_state == FULL)) begin
            bank_d[rd_bank_q] = READ;
        end

        if (release_bank) begin
            bank_d[rd_bank_q] = EMPTY;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // Drive the RAM port from whichever side won this cycle, all zeros when idle.
    always_comb begin
        bus.wr_ready       = grant_wr;
        bus.rd_grant       = grant_rd;
        bus.ram_cs         = grant_wr || grant_rd;
        bus.ram_we         = grant_wr;
        bus.ram_rs         = 1'b0;
        bus.ram_address    = '0;
        bus.ram_data_in    = '0;
        if (grant_wr) begin
            bus.ram_rs      = wr_bank_q;
            bus.ram_address = wr_cnt_q;
            bus.ram_data_in = bus.wr_data;
        end else if (grant_rd) begin
            bus.ram_rs      = rd_bank_q;
            bus.ram_address = bus.rd_addr;
        end
        bus.rd_data_valid  = rd_valid_q;
        bus.rd_data        = rd_valid_q ? bus.ram_data_out : '0;
        bus.rd_frame_avail = frame_avail;
        bus.bank_state     = {bank_q[1], bank_q[0]};
    end

    // State registers; reset drops any partial frame but leaves RAM contents alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]    <= EMPTY;
            bank_q[1]    <= EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_cnt_q     <= '0;
            last_grant_q <= GRANT_WRITE;
            rd_valid_q   <= 1'b0;
        end else begin
            bank_q[0]    <= bank_d[0];
            bank_q[1]    <= bank_d[1];
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            last_grant_q <= last_grant_d;
            rd_valid_q   <= grant_rd;
        end
    end
endmodule

// File: tb/tb_dec_ram_pingpong_ctrl.sv
// Directed bench for the DEC_RAM ping-pong controller: a behavioural
// two-bank RAM, a shadow memory of written words, and a queue of expected
// read data consumed as rd_data_valid appears.
module tb_dec_ram_pingpong_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst;

    dec_ram_pingpong_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dec_ram_pingpong_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RAM_DEPTH (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] ram_mem   [2][DEPTH];
    logic [DW-1:0] model_mem [2][DEPTH];
    logic [DW-1:0] sb_q [$];
    int            checks = 0;
    int            errors = 0;
    logic          exp_wr_bank;
    logic          exp_rd_bank;
    int            exp_wr_cnt;

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural DEC_RAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_we) ram_mem[bus.ram_rs][bus.ram_address] <= bus.ram_data_in;
            else            bus.ram_data_out <= ram_mem[bus.ram_rs][bus.ram_address];
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Read-data monitor: pops the scoreboard whenever the DUT reports valid data.
    always @(negedge clk) begin
        if (bus.rd_data_valid) begin
            check_output("rd_valid_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check_output("rd_data", bus.rd_data, sb_q.pop_front());
        end else begin
            check_output("rd_data_idle", bus.rd_data, 32'd0);
        end
    end

    // Drive one cycle, check grants and RAM port at negedge, then advance the model.
    task automatic apply_stimulus(input logic wv, input logic [DW-1:0] wd, input logic rr,
                                  input logic [AW-1:0] ra, input logic done,
                                  input logic exp_wr, input logic exp_rd, input logic exp_rel);
        bus.wr_valid     = wv;
        bus.wr_data      = wd;
        bus.rd_req       = rr;
        bus.rd_addr      = ra;
        bus.rd_bank_done = done;
        @(negedge clk);
        check_output("wr_ready", bus.wr_ready, exp_wr);
        check_output("rd_grant", bus.rd_grant, exp_rd);
        check_output("ram_cs", bus.ram_cs, exp_wr | exp_rd);
        if (exp_wr) begin
            check_output("wr_ram_we", bus.ram_we, 32'd1);
            check_output("wr_ram_rs", bus.ram_rs, exp_wr_bank);
            check_output("wr_ram_address", bus.ram_address, exp_wr_cnt);
            check_output("wr_ram_data_in", bus.ram_data_in, wd);
            model_mem[exp_wr_bank][exp_wr_cnt] = wd;
        end else if (exp_rd) begin
            check_output("rd_ram_we", bus.ram_we, 32'd0);
            check_output("rd_ram_rs", bus.ram_rs, exp_rd_bank);
            check_output("rd_ram_address", bus.ram_address, ra);
            sb_q.push_back(model_mem[exp_rd_bank][ra]);
        end else begin
            check_output("idle_ram_we", bus.ram_we, 32'd0);
            check_output("idle_ram_address", bus.ram_address, 32'd0);
        end
        @(posedge clk);
        #1;
        if (exp_wr) begin
            if (exp_wr_cnt == DEPTH - 1) begin
                exp_wr_cnt  = 0;
                exp_wr_bank = ~exp_wr_bank;
            end else begin
                exp_wr_cnt++;
            end
        end
        if (exp_rel) exp_rd_bank = ~exp_rd_bank;
        bus.rd_bank_done = 1'b0;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b1, DW'($urandom), 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_wr_ready"}, bus.wr_ready, 32'd0);
        check_output({tag, "_rd_grant"}, bus.rd_grant, 32'd0);
        check_output({tag, "_ram_cs"}, bus.ram_cs, 32'd0);
        check_output({tag, "_ram_we"}, bus.ram_we, 32'd0);
        check_output({tag, "_ram_address"}, bus.ram_address, 32'd0);
        check_output({tag, "_ram_data_in"}, bus.ram_data_in, 32'd0);
        check_output({tag, "_ram_rs"}, bus.ram_rs, 32'd0);
        check_output({tag, "_rd_data_valid"}, bus.rd_data_valid, 32'd0);
        check_output({tag, "_rd_frame_avail"}, bus.rd_frame_avail, 32'd0);
        check_output({tag, "_bank_state"}, bus.bank_state, 32'd0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        rst              = 1'b1;
        bus.wr_valid     = 1'b1;
        bus.wr_data      = '1;
        bus.rd_req       = 1'b0;
        bus.rd_addr      = '0;
        bus.rd_bank_done = 1'b0;
        exp_wr_bank      = 1'b0;
        exp_rd_bank      = 1'b0;
        exp_wr_cnt       = 0;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill bank 0 with wr_valid held high.
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(1'b1, DW'($urandom), 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 0) check_output("fill0_first_state", bus.bank_state, 32'h1);
        end
        check_output("fill0_done_state", bus.bank_state, 32'h2);
        check_output("fill0_frame_avail", bus.rd_frame_avail, 32'd1);

        // Contention: reads win first after reset, then alternate.
        apply_stimulus(1'b1, DW'($urandom), 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, DW'($urandom), 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, DW'($urandom), 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, DW'($urandom), 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("contention_state", bus.bank_state, 32'h7);

        // Complete bank 1, then backpressure with both banks occupied.
        write_words(DEPTH - 2);
        check_output("both_full_state", bus.bank_state, 32'hB);
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, DW'($urandom), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("backpressure_state", bus.bank_state, 32'hB);

        // Read back bank 0 completely, releasing it together with the last read.
        for (int a = 0; a < DEPTH; a++)
            apply_stimulus(1'b1, DW'($urandom), 1'b1, AW'(a), a == DEPTH - 1,
                           1'b0, 1'b1, a == DEPTH - 1);
        check_output("release0_state", bus.bank_state, 32'h8);
        check_output("release0_frame_avail", bus.rd_frame_avail, 32'd1);

        // Writes resume at bank 0 address 0.
        write_words(3);
        check_output("resume_state", bus.bank_state, 32'h9);

        // Release bank 1 without reading, then a release with no frame is ignored.
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("release1_state", bus.bank_state, 32'h1);
        check_output("release1_frame_avail", bus.rd_frame_avail, 32'd0);
        apply_stimulus(1'b0, '0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("ignored_done_state", bus.bank_state, 32'h1);
        check_output("ignored_done_frame_avail", bus.rd_frame_avail, 32'd0);
        write_words(1);

        // Reset mid-frame at wr_cnt=100 with the loader still offering data.
        write_words(96);
        check_output("scoreboard_empty_before_reset", sb_q.size(), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst         = 1'b0;
        exp_wr_bank = 1'b0;
        exp_rd_bank = 1'b0;
        exp_wr_cnt  = 0;
        write_words(2);
        check_output("post_reset_state", bus.bank_state, 32'h1);

        @(negedge clk);
        check_output("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
